// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM state
// encodings and the MemOp access-size codes also used by the control decoder.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_BUSY = 2'd1,
        ST_F_BUSY = 2'd2,
        ST_DONE   = 2'd3
    } arbState_e;

    localparam logic [1:0] MEMOP_B = 2'b00;
    localparam logic [1:0] MEMOP_H = 2'b01;
    localparam logic [1:0] MEMOP_W = 2'b10;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_store_lane_align.sv
// Combinational lane placement for data accesses: derives byte enables,
// replicates store data across the lanes and flags misaligned accesses.
module store_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  memop_i,
    input  logic [1:0]  addrLo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    // Word and the reserved code share the full-width default; byte and half
    // shift their enables to the addressed lane and replicate their data.
    always_comb begin
        be_o       = BE_WORD;
        wdata_o    = wdata_i;
        misalign_o = (addrLo_i != 2'b00);
        case (memop_i)
            MEMOP_B: begin
                be_o       = 4'b0001 << addrLo_i;
                wdata_o    = {4{wdata_i[7:0]}};
                misalign_o = 1'b0;
            end
            MEMOP_H: begin
                be_o       = 4'b0011 << addrLo_i;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addrLo_i[0];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the memory
// stage. Data wins a tie unless it was the last side served, so a pending
// fetch is never starved by back-to-back loads/stores.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_memop_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,
    output logic              d_misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_f_o,
    output logic              stall_m_o
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arbState_e         state_q;
    logic              lastData_q;
    logic              fetchKilled_q;
    logic [1:0]        dOffset_q;
    logic              memReq_q;
    logic              memWe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [3:0]        memBe_q;
    logic [DATA_W-1:0] memWdata_q;
    logic [DATA_W-1:0] ifRdata_q;
    logic              ifValid_q;
    logic [DATA_W-1:0] dRdata_q;
    logic              dValid_q;
    logic              dMisalign_q;

    logic [3:0]        alignBe;
    logic [31:0]       alignWdata;
    logic              alignMisalign;
    logic              grantData;
    logic              grantFetch;

    store_lane_align u_align (
        .memop_i    (d_memop_i),
        .addrLo_i   (d_addr_i[1:0]),
        .wdata_i    (d_wdata_i),
        .be_o       (alignBe),
        .wdata_o    (alignWdata),
        .misalign_o (alignMisalign)
    );

    // Arbitration decision taken in IDLE: data has priority unless it was
    // served last and a fetch is waiting; a kill blocks the fetch grant.
    always_comb begin
        grantData  = d_req_i && (!if_req_i || !lastData_q);
        grantFetch = !grantData && if_req_i && !if_kill_i;
    end

    // Access sequencer with registered memory-side and completion outputs;
    // request fields are latched at grant so they stay stable while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            lastData_q    <= 1'b0;
            fetchKilled_q <= 1'b0;
            dOffset_q     <= 2'b00;
            memReq_q      <= 1'b0;
            memWe_q       <= 1'b0;
            memAddr_q     <= '0;
            memBe_q       <= BE_NONE;
            memWdata_q    <= '0;
            ifRdata_q     <= '0;
            ifValid_q     <= 1'b0;
            dRdata_q      <= '0;
            dValid_q      <= 1'b0;
            dMisalign_q   <= 1'b0;
        end else begin
            ifValid_q   <= 1'b0;
            dValid_q    <= 1'b0;
            dMisalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grantData) begin
                        lastData_q <= 1'b1;
                        if (alignMisalign) begin
                            state_q     <= ST_DONE;
                            dValid_q    <= 1'b1;
                            dMisalign_q <= 1'b1;
                            dRdata_q    <= '0;
                        end else begin
                            state_q    <= ST_D_BUSY;
                            memReq_q   <= 1'b1;
                            memWe_q    <= d_we_i;
                            memAddr_q  <= d_addr_i & WORD_MASK;
                            memBe_q    <= alignBe;
                            memWdata_q <= alignWdata;
                            dOffset_q  <= d_addr_i[1:0];
                        end
                    end else if (grantFetch) begin
                        lastData_q    <= 1'b0;
                        fetchKilled_q <= 1'b0;
                        state_q       <= ST_F_BUSY;
                        memReq_q      <= 1'b1;
                        memWe_q       <= 1'b0;
                        memAddr_q     <= if_addr_i & WORD_MASK;
                        memBe_q       <= BE_WORD;
                        memWdata_q    <= '0;
                    end
                end
                ST_D_BUSY: begin
                    if (mem_ready_i) begin
                        state_q  <= ST_DONE;
                        memReq_q <= 1'b0;
                        memWe_q  <= 1'b0;
                        memBe_q  <= BE_NONE;
                        dValid_q <= 1'b1;
                        dRdata_q <= mem_rdata_i >> {dOffset_q, 3'b000};
                    end
                end
                ST_F_BUSY: begin
                    if (mem_ready_i) begin
                        state_q  <= ST_DONE;
                        memReq_q <= 1'b0;
                        memBe_q  <= BE_NONE;
                        if (!fetchKilled_q && !if_kill_i) begin
                            ifValid_q <= 1'b1;
                            ifRdata_q <= mem_rdata_i;
                        end
                    end else if (if_kill_i) begin
                        fetchKilled_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stalls hold each pipeline stage until its own completion pulse.
    always_comb begin
        stall_f_o = if_req_i & ~ifValid_q;
        stall_m_o = d_req_i & ~dValid_q;
    end

    assign mem_req_o    = memReq_q;
    assign mem_we_o     = memWe_q;
    assign mem_addr_o   = memAddr_q;
    assign mem_be_o     = memBe_q;
    assign mem_wdata_o  = memWdata_q;
    assign if_rdata_o   = ifRdata_q;
    assign if_valid_o   = ifValid_q;
    assign d_rdata_o    = dRdata_q;
    assign d_valid_o    = dValid_q;
    assign d_misalign_o = dMisalign_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the RV32I pipeline between the instruction-fetch stage and the memory stage. It accepts level-held requests from both, arbitrates with data priority plus alternation, and sequences each access through a small FSM. It generates byte enables and write-lane placement from the 2-bit `MemOp` size code produced by the control unit, and drives the fetch and memory stall signals back to the pipeline.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; fixed at 32 for byte-enable logic.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `if_req` in 1: fetch request, level, held until `if_valid`.
- `if_addr` in ADDR_W: fetch address, word-aligned.
- `if_kill` in 1: cancels the outstanding fetch (branch/jump redirect).
- `if_rdata` out 32: fetched instruction.
- `if_valid` out 1: one-cycle completion pulse.
- `d_req` in 1: data request, level, held until `d_valid`.
- `d_we` in 1: 1 = store (`MemWrite`).
- `d_memop` in 2: access size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `d_addr` in ADDR_W: byte address.
- `d_wdata` in 32: store data, LSB-justified.
- `d_rdata` out 32: load data, shifted right by byte offset, not extended.
- `d_valid` out 1: one-cycle completion pulse.
- `d_misalign` out 1: pulses together with `d_valid` on a misaligned access.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: write strobe.
- `mem_addr` out ADDR_W: word address, `{addr[ADDR_W-1:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-placed write data.
- `mem_ready` in 1: memory completes the access in the current cycle.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.
- `stall_f` out 1: `if_req & ~if_valid`.
- `stall_m` out 1: `d_req & ~d_valid`.

## Operation
- FSM states:
  - IDLE to D_BUSY when `d_req` is high and (no `if_req` or `last_d==0`).
  - Otherwise IDLE to F_BUSY when `if_req` is high.
  - D_BUSY/F_BUSY to DONE when `mem_ready` is high.
  - DONE to IDLE unconditionally, pulsing the requester's `*_valid`.
- `last_d` is set when a data grant is made and cleared on a fetch grant. Back-to-back data requests therefore alternate with a pending fetch, so neither side starves.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << addr[1:0]`.
  - Word: `4'b1111`.
- Write data: the byte is replicated to all 4 lanes, the half to both halves; the word passes through unchanged.
- Misaligned accesses are a half with `addr[0]=1` or a word with `addr[1:0]!=0`. These make no memory access: IDLE goes directly to DONE, and `d_valid`, `d_misalign` and `d_rdata=0` are produced.
- `if_kill`:
  - In F_BUSY, the memory access runs to completion (the protocol cannot abort) but `if_valid` is suppressed.
  - In IDLE, it blocks a fetch grant that cycle.
- Address, `we`, `be` and `wdata` are latched at grant and held stable while `mem_req` is high, even if requester inputs change.

## Timing
- Reset values: state IDLE, `last_d=0`, and every output 0, including `mem_req`, `mem_be`, `if_rdata` and `d_rdata`.
- Asynchronous reset mid-access drops `mem_req` immediately; the in-flight access is abandoned.
- Grant at edge t: `mem_req` is high from t+1.
- With `mem_ready` high in the first `mem_req` cycle, `*_valid` is high in cycle t+2, so the minimum latency from request to valid is 2 cycles.
- Each wait cycle with `mem_ready` low adds one cycle.
- `mem_rdata` is captured on the `mem_ready` edge. The `*_rdata` outputs then hold until the next completion of the same requester.
- A misaligned access gives `d_valid` in t+1.
- `mem_ready` while `mem_req` is low is ignored.
- At most one outstanding access.

## Structure
- Shared package/header holds:
  - FSM state encodings.
  - `MemOp` size constants (`MEMOP_B=2'b00`, `MEMOP_H=2'b01`, `MEMOP_W=2'b10`), shared with the control unit decoder.
- One sub-module, `store_lane_align`, is combinational. Inputs are memop, `addr[1:0]` and wdata; outputs are `be`, placed wdata and the misalign flag.

## Test plan
- Fetch only: `if_addr=0x100`, `mem_ready` tied 1. Required: `mem_addr=0x100`, `mem_be=4'hF`, `if_valid` 2 cycles after `if_req`, `if_rdata=mem_rdata`.
- Simultaneous `if_req` and `d_req` (store byte, `addr=0x203`, `wdata=0xAB`). Required:
  - Data granted first with `mem_be=4'b1000`, `mem_wdata=0xABABABAB`, `mem_addr=0x200`.
  - Fetch granted next.
  - `stall_f` high throughout.
- Load half at `0x402`, `mem_rdata=0xBEEF1234`, 3 wait cycles (`mem_ready` low). Required: `mem_req` and `mem_addr` stable for 4 cycles, `d_rdata=0x0000BEEF`, `d_valid` at cycle 6.
- Word load at `0x305`. Required: no `mem_req`, `d_misalign=d_valid=1` the next cycle, `d_rdata=0`.
- `if_kill` during F_BUSY. Required: access completes on `mem_ready`, no `if_valid`, and the next fetch is granted from IDLE.
- Assert `rst_n=0` mid-D_BUSY. Required: `mem_req` drops asynchronously, all outputs 0, FSM IDLE after release.
